// File: rtl/arbitro_mux4.sv
// arbitro_mux4: shares one MUX4_1 output between four requesters.
// Drives the mux sel/enable directly and returns a one-hot grant to the requesters.
// A per-grant quota of MAX_CICLOS cycles applies only while another requester waits.
//
// Handshake: req[i] is a level request. grant[i] (registered) means requester i owns
// the mux. The owner keeps ownership for as long as it holds req[i], unless its quota
// is used up while another requester is waiting. Dropping req[i] releases ownership at
// the next rising edge. Pending requests are handed over in that same edge, so there is
// no idle cycle between owners.
//
// Optional build macro: ARB_PRIO_FIXA_EN.
//   Defined:   fixed priority. The lowest requesting index wins.
//   Undefined: round-robin starting after the last owner (the default).
module arbitro_mux4 #(
  parameter int MAX_CICLOS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [1:0] sel,
  output logic       enable,
  output logic [3:0] grant,
  output logic       ocupado,
  output logic       estado_dbg
);

  typedef enum logic {OCIOSO = 1'b0, CONCEDIDO = 1'b1} estado_t;

`ifdef ARB_PRIO_FIXA_EN
  localparam logic FIXA = 1'b1;
`else
  localparam logic FIXA = 1'b0;
`endif

  localparam logic [3:0] MAX_C = 4'(MAX_CICLOS);

  estado_t    r_estado, w_estado;
  logic [1:0] r_sel, w_sel;
  logic       r_enable, w_enable;
  logic [3:0] r_grant, w_grant;
  logic [3:0] r_cnt, w_cnt;
  logic [1:0] r_ptr, w_ptr;

  logic [1:0] w_base_ocioso;
  logic [1:0] w_base_dono;
  logic [3:0] w_req_outros;
  logic [1:0] w_ganador_ocioso;
  logic [1:0] w_ganador_livre;
  logic [1:0] w_ganador_cota;

  // Returns the first requesting index in the order base+1, base+2, base+3, base.
  // With base=3 this is plain lowest-index priority.
  function automatic logic [1:0] f_ganador(input logic [3:0] i_req, input logic [1:0] i_base);
    logic [1:0] v_idx;
    f_ganador = i_base;
    for (int k = 4; k >= 1; k--) begin
      v_idx = i_base + 2'(k);
      if (i_req[v_idx]) f_ganador = v_idx;
    end
  endfunction

  // Search bases and candidate winners for each arbitration case.
  always_comb begin
    w_base_ocioso    = FIXA ? 2'd3 : r_ptr;
    w_base_dono      = FIXA ? 2'd3 : r_sel;
    w_req_outros     = req & ~(4'b0001 << r_sel);
    w_ganador_ocioso = f_ganador(req, w_base_ocioso);
    w_ganador_livre  = f_ganador(req, w_base_dono);
    w_ganador_cota   = f_ganador(w_req_outros, w_base_dono);
  end

  // Next-state and next-output logic. The release rule takes priority over the quota rule.
  always_comb begin
    w_estado = r_estado;
    w_sel    = r_sel;
    w_enable = r_enable;
    w_grant  = r_grant;
    w_cnt    = r_cnt;
    w_ptr    = r_ptr;
    case (r_estado)
      OCIOSO: begin
        if (req != 4'b0000) begin
          w_estado = CONCEDIDO;
          w_sel    = w_ganador_ocioso;
          w_enable = 1'b1;
          w_grant  = 4'b0001 << w_ganador_ocioso;
          w_cnt    = 4'd1;
          w_ptr    = w_ganador_ocioso;
        end
      end
      CONCEDIDO: begin
        if (!req[r_sel]) begin
          if (req != 4'b0000) begin
            w_sel   = w_ganador_livre;
            w_grant = 4'b0001 << w_ganador_livre;
            w_cnt   = 4'd1;
            w_ptr   = w_ganador_livre;
          end else begin
            // sel keeps its value so the mux input does not glitch while idle.
            w_estado = OCIOSO;
            w_enable = 1'b0;
            w_grant  = 4'b0000;
            w_cnt    = 4'd0;
          end
        end else if ((r_cnt == MAX_C) && (w_req_outros != 4'b0000)) begin
          w_sel   = w_ganador_cota;
          w_grant = 4'b0001 << w_ganador_cota;
          w_cnt   = 4'd1;
          w_ptr   = w_ganador_cota;
        end else if (r_cnt != MAX_C) begin
          w_cnt = r_cnt + 4'd1;
        end
      end
      default: begin
        w_estado = OCIOSO;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= OCIOSO;
      r_sel    <= 2'b00;
      r_enable <= 1'b0;
      r_grant  <= 4'b0000;
      r_cnt    <= 4'd0;
      r_ptr    <= 2'd3;
    end else begin
      r_estado <= w_estado;
      r_sel    <= w_sel;
      r_enable <= w_enable;
      r_grant  <= w_grant;
      r_cnt    <= w_cnt;
      r_ptr    <= w_ptr;
    end
  end

  // Outputs come straight from the registers.
  always_comb begin
    sel        = r_sel;
    enable     = r_enable;
    grant      = r_grant;
    ocupado    = r_enable;
    estado_dbg = (r_estado == CONCEDIDO);
  end

endmodule

// File: tb/tb_arbitro_mux4.sv
// Bench for arbitro_mux4. The driver pushes the expected post-edge outputs.
// The monitor pops them and compares them one cycle later.
module tb_arbitro_mux4;

  localparam int MAXC = 4;
  localparam int W    = 9;

  logic       clock;
  logic       reset;
  logic [3:0] req;
  logic [1:0] sel;
  logic       enable;
  logic [3:0] grant;
  logic       ocupado;
  logic       estado_dbg;

  logic [W-1:0] exp_q[$];
  int n_chk;
  int n_err;
  int cyc;

  // Reference model state: owner index (-1 = idle), cycles held, last owner, mux select.
  int m_own;
  int m_held;
  int m_last;
  int m_sel;

  arbitro_mux4 #(.MAX_CICLOS(MAXC)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .sel        (sel),
    .enable     (enable),
    .grant      (grant),
    .ocupado    (ocupado),
    .estado_dbg (estado_dbg)
  );

  // Clock and cycle counter.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Picks a winner from the requesters, skipping index excl.
  // Fixed priority returns the lowest index.
  // Round-robin returns the first index after the last owner.
  function automatic int pick(input logic [3:0] r, input int last, input int excl);
    int idx;
`ifdef ARB_PRIO_FIXA_EN
    for (int i = 0; i < 4; i++)
      if (r[i] && i != excl) return i;
`else
    for (int k = 1; k <= 4; k++) begin
      idx = (last + k) % 4;
      if (r[idx] && idx != excl) return idx;
    end
`endif
    return -1;
  endfunction

  // Advances the model by one edge and returns the outputs expected after that edge.
  function automatic logic [W-1:0] model_step(input logic rst, input logic [3:0] r);
    int w;
    logic [3:0] g;
    if (rst) begin
      m_own = -1; m_held = 0; m_last = 3; m_sel = 0;
    end else if (m_own < 0) begin
      w = pick(r, m_last, -1);
      if (w >= 0) begin m_own = w; m_held = 1; m_last = w; m_sel = w; end
    end else if (!r[m_own]) begin
      w = pick(r, m_own, -1);
      if (w >= 0) begin m_own = w; m_held = 1; m_last = w; m_sel = w; end
      else begin m_own = -1; m_held = 0; end
    end else begin
      w = (m_held >= MAXC) ? pick(r, m_own, m_own) : -1;
      if (w >= 0) begin m_own = w; m_held = 1; m_last = w; m_sel = w; end
      else if (m_held < MAXC) m_held++;
    end
    g = (m_own >= 0) ? (4'b0001 << m_own) : 4'b0000;
    return {m_own >= 0, 2'(m_sel), m_own >= 0, g, m_own >= 0};
  endfunction

  // Driver task: applies one cycle of stimulus and pushes the expected response.
  task automatic drive(input logic rst, input logic [3:0] r);
    @(negedge clock);
    reset = rst;
    req   = r;
    exp_q.push_back(model_step(rst, r));
  endtask

  // Monitor: outputs are visible every cycle, so compare after each rising edge.
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] got;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {estado_dbg, sel, enable, grant, ocupado};
        n_chk++;
        if (got !== e) begin
          n_err++;
          $display("FAIL outputs cyc=%0d req=%b rst=%b: got st=%b sel=%b en=%b gnt=%b oc=%b, expected st=%b sel=%b en=%b gnt=%b oc=%b",
                   cyc, req, reset, got[8], got[7:6], got[5], got[4:1], got[0],
                   e[8], e[7:6], e[5], e[4:1], e[0]);
        end
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin
    logic [3:0] r;
    n_chk = 0; n_err = 0; cyc = 0;
    m_own = -1; m_held = 0; m_last = 3; m_sel = 0;
    reset = 1'b1;
    req   = 4'b1111;

    // Reset held with all requests asserted.
    repeat (2) drive(1'b1, 4'b1111);
    // Single requester 2, then release.
    repeat (5) drive(1'b0, 4'b0100);
    repeat (3) drive(1'b0, 4'b0000);
    // Full contention.
    drive(1'b1, 4'b0000);
    repeat (22) drive(1'b0, 4'b1111);
    // Lone requester keeps its grant.
    drive(1'b1, 4'b0000);
    repeat (20) drive(1'b0, 4'b0010);
    // Owner 1 drops while requester 3 rises.
    drive(1'b0, 4'b1000);
    repeat (2) drive(1'b0, 4'b1000);
    // Reset in the middle of a grant, then contention from index 0.
    repeat (3) drive(1'b0, 4'b0100);
    drive(1'b1, 4'b0100);
    repeat (6) drive(1'b0, 4'b1111);
    // Owner re-raises after losing the grant.
    repeat (2) drive(1'b0, 4'b0011);
    repeat (8) drive(1'b0, 4'b0111);

    // Randomized traffic with occasional resets.
    r = 4'($urandom_range(0, 15));
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 99) == 0), r);
    end

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clock);
    #2;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
